// File: rtl/adc_pkg.sv
// adc_pkg: types and helpers shared by the ADC sample scheduler, the ADC data
// path and the bench.
//   sched_state_t : scheduler FSM state encoding
//   ADC_WIDTH_DEFAULT : default ADC sample width in bits
//   acc_width()   : accumulator width that holds 2**log2_n full-scale samples
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    REQ     = 3'd2,
    ACCUM   = 3'd3,
    PUBLISH = 3'd4
  } sched_state_t;

  localparam int ADC_WIDTH_DEFAULT = 12;

  // Sum of 2**log2_n samples of adc_w bits never needs more than adc_w+log2_n bits.
  function automatic int acc_width(input int adc_w, input int log2_n);
    return adc_w + log2_n;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: enable-gated period counter for the ADC sample scheduler.
// Counts 0..SAMPLE_PERIOD-1 while enabled and raises tick for the one cycle
// the count sits at its terminal value. The count is held at 0 while disabled,
// so the first tick after enable comes one full period later.
// Ports:
//   clk_i    in  system clock, rising edge
//   rst_i    in  asynchronous active-high reset
//   enable_i in  1 = count, 0 = hold count at 0
//   tick_o   out one-cycle tick at terminal count
module sample_tick_gen #(
  parameter int SAMPLE_PERIOD = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = enable_i && (cnt_q == TERM);

endmodule

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: issues periodic ADC conversion requests over a req/ack
// handshake, accumulates 2**LOG2_N samples and publishes their truncated
// average. freeze holds the published value and discards the block. Lost
// ticks (overrun) and unanswered requests (timeout) raise sticky flags that
// clear_err clears; a flag being set in the clear cycle stays set.
// Ports:
//   clk         in  system clock, rising edge
//   reset       in  asynchronous active-high reset
//   enable      in  1 = run sampling, 0 = stop after any in-flight request
//   freeze      in  1 = hold ave_out and suppress ave_valid
//   clear_err   in  one-cycle pulse clearing the sticky error flags
//   adc_req     out conversion request, held until ack or timeout
//   adc_ack     in  conversion done, adc_data valid this cycle
//   adc_data    in  conversion result
//   ave_out     out latest published average
//   ave_valid   out one-cycle strobe when ave_out updates
//   busy        out high in every state except IDLE
//   timeout_err out sticky: a request timed out
//   overrun_err out sticky: a tick arrived outside WAIT
module adc_sample_scheduler
  import adc_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50000,
  parameter int ADC_WIDTH     = ADC_WIDTH_DEFAULT,
  parameter int LOG2_N        = 8,
  parameter int TIMEOUT       = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 freeze,
  input  logic                 clear_err,
  output logic                 adc_req,
  input  logic                 adc_ack,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic [ADC_WIDTH-1:0] ave_out,
  output logic                 ave_valid,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 overrun_err
);

  localparam int ACC_W = acc_width(ADC_WIDTH, LOG2_N);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  // Counter value seen at the edge on which the request has been high TIMEOUT cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic tick;

  sample_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk_i   (clk),
    .rst_i   (reset),
    .enable_i(enable),
    .tick_o  (tick)
  );

  sched_state_t            state_q, state_d;
  logic                    req_q, req_d;
  logic [ADC_WIDTH-1:0]    sample_q, sample_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [LOG2_N-1:0]       cnt_q, cnt_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic [ADC_WIDTH-1:0]    ave_q, ave_d;
  logic                    vld_q, vld_d;
  logic                    busy_q, busy_d;
  logic                    terr_q, terr_d;
  logic                    oerr_q, oerr_d;
  logic                    terr_set;
  logic                    oerr_set;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    sample_d = sample_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    ave_d    = ave_q;
    vld_d    = 1'b0;
    terr_set = 1'b0;
    // Only WAIT can accept a tick; anywhere else the tick is lost.
    oerr_set = tick && (state_q != WAIT);

    case (state_q)
      IDLE: begin
        // Any partial block left by a disable is dropped here.
        acc_d = '0;
        cnt_d = '0;
        if (enable) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (tick) begin
          state_d = REQ;
          req_d   = 1'b1;
          to_d    = '0;
        end
      end
      REQ: begin
        // Ack has priority over a timeout falling in the same cycle.
        if (adc_ack) begin
          sample_d = adc_data;
          req_d    = 1'b0;
          state_d  = ACCUM;
        end else if (to_q == TO_LAST) begin
          req_d    = 1'b0;
          terr_set = 1'b1;
          state_d  = WAIT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_W'(sample_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = PUBLISH;
        end else begin
          state_d = enable ? WAIT : IDLE;
        end
      end
      PUBLISH: begin
        if (!freeze) begin
          ave_d = ADC_WIDTH'(acc_q >> LOG2_N);
          vld_d = 1'b1;
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = enable ? WAIT : IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
    terr_d = terr_set | (terr_q & ~clear_err);
    oerr_d = oerr_set | (oerr_q & ~clear_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      sample_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      ave_q    <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sample_q <= sample_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      ave_q    <= ave_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      oerr_q   <= oerr_d;
    end
  end

  assign adc_req     = req_q;
  assign ave_out     = ave_q;
  assign ave_valid   = vld_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign overrun_err = oerr_q;

endmodule
